xc_aesmix: RTL and testbench

Lightweight AES MixColumns / InvMixColumns instruction unit, the stage directly downstream of the AES SubBytes instruction in the crypto ISE datapath. It consumes two 32-bit source registers holding SubBytes-processed state bytes and produces one fully mixed 32-bit column. The byte selection folds ShiftRows in, so a SubBytes → MixColumns instruction pair performs a full AES round body per column. It sits in the execute stage beside the other xc_* functional units and shares the same valid/ready/flush handshake.

---
 rtl/xc_aesmix.sv | 116 +++++++++++
 tb/tb_xc_aesmix.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/xc_aesmix.sv
// AES MixColumns / InvMixColumns column unit with ShiftRows-folded operand selection.
// Build option: XC_AESMIX_FAST_EN selects the single-cycle four-datapath variant.
module xc_aesmix (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_data,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  output logic        ready,
  output logic [31:0] result
);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One output byte: a0 is the byte on the diagonal, a1..a3 follow cyclically.
  function automatic logic [7:0] mix_byte(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3,
                                          input logic enc_i);
    logic [7:0] a0_2, a0_4, a0_8, a1_2, a1_4, a1_8;
    logic [7:0] a2_2, a2_4, a2_8, a3_2, a3_4, a3_8;
    a0_2 = xtime(a0);  a0_4 = xtime(a0_2);  a0_8 = xtime(a0_4);
    a1_2 = xtime(a1);  a1_4 = xtime(a1_2);  a1_8 = xtime(a1_4);
    a2_2 = xtime(a2);  a2_4 = xtime(a2_2);  a2_8 = xtime(a2_4);
    a3_2 = xtime(a3);  a3_4 = xtime(a3_2);  a3_8 = xtime(a3_4);
    if (enc_i) begin
      mix_byte = a0_2 ^ a1_2 ^ a1 ^ a2 ^ a3;
    end else begin
      mix_byte = (a0_8 ^ a0_4 ^ a0_2) ^ (a1_8 ^ a1_2 ^ a1) ^
                 (a2_8 ^ a2_4 ^ a2) ^ (a3_8 ^ a3);
    end
  endfunction

  // Operands gated by valid so the datapath stays quiet while idle.
  logic [7:0] op0_s, op1_s, op2_s, op3_s;
  assign op0_s = rs1[7:0]   & {8{valid}};
  assign op1_s = rs1[15:8]  & {8{valid}};
  assign op2_s = rs2[23:16] & {8{valid}};
  assign op3_s = rs2[31:24] & {8{valid}};

`ifdef XC_AESMIX_FAST_EN

  logic unused_s;
  assign unused_s = ^{clock, reset, flush, flush_data, rs1[31:16], rs2[15:0]};

  assign ready  = valid;
  assign result = {mix_byte(op3_s, op0_s, op1_s, op2_s, enc),
                   mix_byte(op2_s, op3_s, op0_s, op1_s, enc),
                   mix_byte(op1_s, op2_s, op3_s, op0_s, enc),
                   mix_byte(op0_s, op1_s, op2_s, op3_s, enc)};

`else

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  logic [1:0] state_r;
  logic [7:0] b0_r, b1_r, b2_r;
  logic [7:0] m0_s, m1_s, m2_s, m3_s, o_s;
  logic       unused_s;

  assign unused_s = ^{rs1[31:16], rs2[15:0]};

  // Rotate operands so the shared datapath computes o_i in state S_i.
  always_comb begin
    m0_s = 8'h00;
    m1_s = 8'h00;
    m2_s = 8'h00;
    m3_s = 8'h00;
    case (state_r)
      S0: begin m0_s = op0_s; m1_s = op1_s; m2_s = op2_s; m3_s = op3_s; end
      S1: begin m0_s = op1_s; m1_s = op2_s; m2_s = op3_s; m3_s = op0_s; end
      S2: begin m0_s = op2_s; m1_s = op3_s; m2_s = op0_s; m3_s = op1_s; end
      S3: begin m0_s = op3_s; m1_s = op0_s; m2_s = op1_s; m3_s = op2_s; end
      default: begin m0_s = 8'h00; m1_s = 8'h00; m2_s = 8'h00; m3_s = 8'h00; end
    endcase
  end

  assign o_s    = mix_byte(m0_s, m1_s, m2_s, m3_s, enc);
  assign ready  = valid && (state_r == S3);
  assign result = {o_s, b2_r, b1_r, b0_r};

  // Byte-serial sequencer: capture o0..o2, then present o3 combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S0;
      b0_r    <= 8'h00;
      b1_r    <= 8'h00;
      b2_r    <= 8'h00;
    end else if (flush) begin
      state_r <= S0;
      b0_r    <= flush_data[7:0];
      b1_r    <= flush_data[15:8];
      b2_r    <= flush_data[23:16];
    end else if (valid) begin
      case (state_r)
        S0: begin b0_r <= o_s; state_r <= S1; end
        S1: begin b1_r <= o_s; state_r <= S2; end
        S2: begin b2_r <= o_s; state_r <= S3; end
        S3: state_r <= S0;
        default: state_r <= S0;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

`endif

endmodule

// File: tb/tb_xc_aesmix.sv
// Self-checking bench for xc_aesmix: fixed vectors, randomized columns against a
// generic GF(2^8) matrix model, and stall/flush/reset sequences.
module tb_xc_aesmix;

  logic        clock, reset, flush, valid, enc, ready;
  logic [31:0] flush_data, rs1, rs2, result;
  int          checks = 0;
  int          errors = 0;

`ifdef XC_AESMIX_FAST_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif

  xc_aesmix dut (
    .clock(clock), .reset(reset), .flush(flush), .flush_data(flush_data),
    .valid(valid), .rs1(rs1), .rs2(rs2), .enc(enc), .ready(ready), .result(result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        e;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  // Generic shift-and-add GF(2^8) multiply, reduced by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] model(input logic [31:0] r1, input logic [31:0] r2,
                                        input logic e);
    logic [7:0] a[4];
    logic [7:0] c[4];
    logic [7:0] o;
    logic [31:0] res;
    a[0] = r1[7:0]; a[1] = r1[15:8]; a[2] = r2[23:16]; a[3] = r2[31:24];
    if (e) begin c[0] = 8'd2;  c[1] = 8'd3;  c[2] = 8'd1;  c[3] = 8'd1; end
    else   begin c[0] = 8'd14; c[1] = 8'd11; c[2] = 8'd13; c[3] = 8'd9; end
    res = 32'h0;
    for (int i = 0; i < 4; i++) begin
      o = 8'h00;
      for (int j = 0; j < 4; j++) o = o ^ gmul(c[j], a[(i + j) % 4]);
      res[8*i +: 8] = o;
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Hold valid with one operand set for a full operation and check ready timing.
  task automatic run_op(input logic [31:0] r1, input logic [31:0] r2, input logic e,
                        input logic [31:0] exp, input string name);
    rs1 = r1; rs2 = r2; enc = e; valid = 1'b1;
    for (int c = 1; c < LAT; c++) begin
      @(negedge clock);
      check({name, " early ready"}, {31'b0, ready}, 32'd0);
      next_cycle();
    end
    @(negedge clock);
    check({name, " ready"}, {31'b0, ready}, 32'd1);
    check({name, " result"}, result, exp);
    next_cycle();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; flush_data = 32'h0; valid = 1'b0;
    rs1 = 32'h0; rs2 = 32'h0; enc = 1'b1;
    vecs[0] = '{32'h000013DB, 32'h45530000, 1'b1, 32'hBCA14D8E};
    vecs[1] = '{32'h00004D8E, 32'hBCA10000, 1'b0, 32'h455313DB};
    vecs[2] = '{32'h00000AF2, 32'h5C220000, 1'b1, 32'h9D58DC9F};
    vecs[3] = '{32'h00000101, 32'h01010000, 1'b1, 32'h01010101};
    vecs[4] = '{32'h00000101, 32'h01010000, 1'b0, 32'h01010101};
    vecs[5] = '{32'h0000C6C6, 32'hC6C60000, 1'b1, 32'hC6C6C6C6};
    vecs[6] = '{32'h0000C6C6, 32'hC6C60000, 1'b0, 32'hC6C6C6C6};
    vecs[7] = '{32'hFFFF0AF2, 32'h5C22FFFF, 1'b1, 32'h9D58DC9F};

    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    check("reset ready", {31'b0, ready}, 32'd0);
    check("reset result", result, 32'h0);
    next_cycle();

    // Table vectors issued back-to-back with valid held high throughout.
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].r1, vecs[i].r2, vecs[i].e, vecs[i].exp, $sformatf("vec%0d", i));
    valid = 1'b0;
    next_cycle();

    for (int i = 0; i < 30; i++) begin
      logic [31:0] r1, r2;
      logic        e;
      r1 = $urandom; r2 = $urandom; e = 1'($urandom_range(0, 1));
      run_op(r1, r2, e, model(r1, r2, e), $sformatf("rand%0d", i));
    end
    valid = 1'b0;
    next_cycle();

`ifndef XC_AESMIX_FAST_EN
    // Stall in S2: partial bytes must hold and ready follow 2 valid cycles later.
    rs1 = vecs[0].r1; rs2 = vecs[0].r2; enc = 1'b1; valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      check("stall pre ready", {31'b0, ready}, 32'd0);
      next_cycle();
    end
    valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("stall ready", {31'b0, ready}, 32'd0);
      check("stall hold", {16'h0, result[15:0]}, 32'h00004D8E);
      next_cycle();
    end
    valid = 1'b1;
    @(negedge clock);
    check("resume ready1", {31'b0, ready}, 32'd0);
    next_cycle();
    @(negedge clock);
    check("resume ready2", {31'b0, ready}, 32'd1);
    check("resume result", result, 32'hBCA14D8E);
    next_cycle();

    // Flush together with valid: flush wins and loads partial registers.
    flush = 1'b1; flush_data = 32'hA5A55A5A;
    rs1 = vecs[2].r1; rs2 = vecs[2].r2;
    @(negedge clock);
    check("flush ready", {31'b0, ready}, 32'd0);
    next_cycle();
    flush = 1'b0; valid = 1'b0;
    @(negedge clock);
    check("flush bregs", result, 32'h00A55A5A);
    check("flush idle ready", {31'b0, ready}, 32'd0);
    next_cycle();
    run_op(vecs[2].r1, vecs[2].r2, 1'b1, 32'h9D58DC9F, "post flush");

    // Flush mid-operation, then a full-length operation.
    for (int c = 0; c < 2; c++) next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    run_op(vecs[1].r1, vecs[1].r2, 1'b0, 32'h455313DB, "midflush");

    // Reset mid-operation, then a full-length operation.
    rs1 = vecs[0].r1; rs2 = vecs[0].r2; enc = 1'b1;
    for (int c = 0; c < 3; c++) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    run_op(vecs[0].r1, vecs[0].r2, 1'b1, 32'hBCA14D8E, "midreset");
    valid = 1'b0;
    next_cycle();
`else
    valid = 1'b0;
    @(negedge clock);
    check("fast idle ready", {31'b0, ready}, 32'd0);
    next_cycle();
    flush = 1'b1; flush_data = 32'hA5A55A5A;
    rs1 = vecs[2].r1; rs2 = vecs[2].r2; enc = 1'b1; valid = 1'b1;
    @(negedge clock);
    check("fast flush ready", {31'b0, ready}, 32'd1);
    check("fast flush result", result, 32'h9D58DC9F);
    next_cycle();
    flush = 1'b0; valid = 1'b0;
    next_cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
